// File: rtl/cpu_pkg.sv
// Constants shared by the control unit and the instruction fetch unit:
// bus widths, opcodes, datapath path types and command-word field positions.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 24;
  localparam int unsigned FIELD_W = 8;

  localparam int unsigned OPC_LSB = 16;
  localparam int unsigned OP1_LSB = 8;
  localparam int unsigned OP2_LSB = 0;

  localparam logic [FIELD_W-1:0] STR_IMM = 8'h01;
  localparam logic [FIELD_W-1:0] STR_REG = 8'h02;
  localparam logic [FIELD_W-1:0] LOAD    = 8'h03;
  localparam logic [FIELD_W-1:0] ADD_REG = 8'h04;
  localparam logic [FIELD_W-1:0] SUB_REG = 8'h05;
  localparam logic [FIELD_W-1:0] JMP     = 8'h06;
  localparam logic [FIELD_W-1:0] JZ      = 8'h07;
  localparam logic [FIELD_W-1:0] CALL    = 8'h08;
  localparam logic [FIELD_W-1:0] RET     = 8'h09;

  localparam logic [1:0] PATH_NONE   = 2'd0;
  localparam logic [1:0] PATH_ALU    = 2'd1;
  localparam logic [1:0] PATH_MEM    = 2'd2;
  localparam logic [1:0] PATH_BRANCH = 2'd3;

  typedef struct packed {
    logic [FIELD_W-1:0] opcode;
    logic [FIELD_W-1:0] op1;
    logic [FIELD_W-1:0] op2;
  } cmd_t;

  function automatic logic [FIELD_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO with sticky overflow/underflow flags.
// A simultaneous push and pop on a non-empty stack swaps the top entry in place.
module pc_return_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_val,
  output logic [W-1:0] top_c,
  output logic         empty_c,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned SP_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             full;

  assign empty_c   = (sp_q == '0);
  assign full      = (sp_q == SP_W'(DEPTH));
  assign top_idx   = IDX_W'(sp_q - SP_W'(1));
  assign top_c     = mem_q[top_idx];
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = IDX_W'(sp_q);
    if (push && pop && !empty_c) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      // pop reaching here means the stack was empty
      if (pop) unf_d = 1'b1;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SP_W'(1);
      end
    end else if (pop) begin
      if (empty_c) unf_d = 1'b1;
      else         sp_d  = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_val;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch responder for the control unit: owns PC, MAR, IR, the return stack
// and the single-outstanding instruction-memory read handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_en,
  input  logic [ADDR_W-1:0]  pc_load_val,
  input  logic               pc_inc,
  input  logic               mar_load,
  input  logic               ir_load,
  input  logic               call_push,
  input  logic               ret_pop,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic [INSTR_W-1:0] command_word,
  output logic               ready_reg_flag,
  output logic [ADDR_W-1:0]  pc_current_value,
  output logic               stack_overflow,
  output logic               stack_underflow,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  cmd_t              ir_q, ir_d;
  cmd_t              buf_q, buf_d;
  logic              ready_q, ready_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] stk_top_c;
  logic              stk_empty_c;
  logic              pop_take;

  pc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (call_push),
    .pop       (ret_pop),
    .push_val  (pc_q),
    .top_c     (stk_top_c),
    .empty_c   (stk_empty_c),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

  assign pop_take = ret_pop && !stk_empty_c;

  // PC priority: explicit load, then return address, then increment
  always_comb begin
    pc_d = pc_q;
    if (pc_en)         pc_d = pc_load_val;
    else if (pop_take) pc_d = stk_top_c;
    else if (pc_inc)   pc_d = pc_q + ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    buf_d   = buf_q;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        if (mar_load) begin
          mar_d   = pc_q;
          ready_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          buf_d   = cmd_t'(mem_rdata);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ir_load) begin
          ir_d    = buf_q;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      buf_q     <= '0;
      ready_q   <= 1'b0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      buf_q     <= buf_d;
      ready_q   <= ready_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_addr         = mar_q;
  assign command_word     = ir_q;
  assign ready_reg_flag   = ready_q;
  assign pc_current_value = pc_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios then random traffic,
// checked against a queue-based reference model and a latency-randomised memory.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pc_en = 1'b0, pc_inc = 1'b0, mar_load = 1'b0, ir_load = 1'b0;
  logic         call_push = 1'b0, ret_pop = 1'b0;
  logic [7:0]   pc_load_val = 8'h00;
  logic         mem_rvalid = 1'b0;
  logic [23:0]  mem_rdata = 24'h0;
  logic         mem_req, ready_reg_flag, stack_overflow, stack_underflow, busy;
  logic [7:0]   mem_addr, pc_current_value;
  logic [23:0]  command_word;

  always #5 clk = ~clk;

  instr_fetch_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_load_val(pc_load_val), .pc_inc(pc_inc),
    .mar_load(mar_load), .ir_load(ir_load), .call_push(call_push), .ret_pop(ret_pop),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .command_word(command_word), .ready_reg_flag(ready_reg_flag),
    .pc_current_value(pc_current_value), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // reference model state
  logic [7:0]  m_pc = 8'h00, m_mar = 8'h00;
  logic [23:0] m_cmd = 24'h0, m_buf = 24'h0;
  bit          m_ready = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  int          m_phase = 0;   // 0 idle, 1 requesting, 2 awaiting data, 3 data held
  logic [7:0]  m_stack[$];
  logic [7:0]  exp_addr_q[$];
  logic [23:0] exp_cmd_q[$];

  function automatic void model_step();
    logic [7:0] old_pc;
    logic [7:0] popped;
    bit         pop_ok;
    if (rst) begin
      m_pc = 8'h00; m_mar = 8'h00; m_cmd = 24'h0; m_buf = 24'h0;
      m_ready = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_phase = 0;
      m_stack.delete(); exp_addr_q.delete(); exp_cmd_q.delete();
      return;
    end
    old_pc = m_pc;
    pop_ok = ret_pop && (m_stack.size() > 0);
    popped = pop_ok ? m_stack[m_stack.size()-1] : 8'h00;
    if (call_push && ret_pop) begin
      if (m_stack.size() > 0) m_stack[m_stack.size()-1] = old_pc;
      else begin m_stack.push_back(old_pc); m_unf = 1'b1; end
    end else if (call_push) begin
      if (m_stack.size() == DEPTH) m_ovf = 1'b1;
      else m_stack.push_back(old_pc);
    end else if (ret_pop) begin
      if (m_stack.size() == 0) m_unf = 1'b1;
      else void'(m_stack.pop_back());
    end
    if (pc_en)       m_pc = pc_load_val;
    else if (pop_ok) m_pc = popped;
    else if (pc_inc) m_pc = 8'(old_pc + 8'd1);
    case (m_phase)
      0: if (mar_load) begin m_mar = old_pc; exp_addr_q.push_back(old_pc); m_ready = 1'b0; m_phase = 1; end
      1: m_phase = 2;
      2: if (mem_rvalid) begin m_buf = mem_rdata; m_phase = 3; end
      default: if (ir_load) begin m_cmd = m_buf; m_ready = 1'b1; exp_cmd_q.push_back(m_buf); m_phase = 0; end
    endcase
  endfunction

  // memory responder
  logic [23:0] rom [256];
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [7:0]  paddr = 8'h00;
  int          fixed_lat = 2;
  bit          stray_en = 1'b0;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin mem_rvalid = 1'b1; mem_rdata = rom[paddr]; pend = 1'b0; end
    end else if (stray_en && $urandom_range(0, 9) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 24'($urandom);
    end
    if (mem_req === 1'b1) begin
      pend  = 1'b1;
      paddr = mem_addr;
      cnt   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
  end

  // monitor: per-cycle state plus scoreboard pops on request / fresh word
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    chk("pc", 32'(pc_current_value), 32'(m_pc));
    chk("mem_addr", 32'(mem_addr), 32'(m_mar));
    chk("command_word", 32'(command_word), 32'(m_cmd));
    chk("ready", 32'(ready_reg_flag), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("overflow", 32'(stack_overflow), 32'(m_ovf));
    chk("underflow", 32'(stack_underflow), 32'(m_unf));
    if (mem_req === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL req_sb: unexpected mem_req addr %0h at %0t", mem_addr, $time);
      end else chk("req_addr_sb", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (ready_reg_flag === 1'b1 && !prev_ready) begin
      if (exp_cmd_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_sb: unexpected ready with word %0h at %0t", command_word, $time);
      end else chk("cmd_sb", 32'(command_word), 32'(exp_cmd_q.pop_front()));
    end
    prev_ready = ready_reg_flag;
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    pc_en = 1'b0; pc_inc = 1'b0; mar_load = 1'b0; ir_load = 1'b0;
    call_push = 1'b0; ret_pop = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input string name);
    int k = 0;
    while (m_phase != ph && k < 50) begin tick(); k++; end
    n_cmp++;
    if (m_phase != ph) begin
      n_bad++;
      $display("FAIL %s: timeout, model phase %0d wanted %0d", name, m_phase, ph);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
    rom[0] = 24'h01032A;
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // ir_load in IDLE is ignored
    ir_load = 1'b1; tick(); ir_load = 1'b0;
    chk("ir_load_idle_ready", 32'(ready_reg_flag), 32'd0);

    // first fetch from PC 0
    fixed_lat = 2;
    mar_load = 1'b1; tick(); mar_load = 1'b0;
    chk("fetch0_req", 32'(mem_req), 32'd1);
    chk("fetch0_addr", 32'(mem_addr), 32'd0);
    wait_phase(3, "fetch0_data");
    ir_load = 1'b1; tick(); ir_load = 1'b0;
    chk("fetch0_cmd", 32'(command_word), 32'h01032A);
    chk("fetch0_ready", 32'(ready_reg_flag), 32'd1);

    // PC priority and wrap
    pc_inc = 1'b1; tick(); tick(); tick();
    chk("pc_inc3", 32'(pc_current_value), 32'h03);
    pc_en = 1'b1; pc_load_val = 8'h40; tick(); pc_inc = 1'b0; pc_en = 1'b0;
    chk("pc_en_over_inc", 32'(pc_current_value), 32'h40);
    pc_en = 1'b1; pc_load_val = 8'hFF; tick(); pc_en = 1'b0;
    pc_inc = 1'b1; tick(); pc_inc = 1'b0;
    chk("pc_wrap", 32'(pc_current_value), 32'h00);

    // CALL / RET
    pc_en = 1'b1; pc_load_val = 8'h12; tick();
    call_push = 1'b1; pc_load_val = 8'h80; tick(); call_push = 1'b0; pc_en = 1'b0;
    chk("call_pc", 32'(pc_current_value), 32'h80);
    tick();
    ret_pop = 1'b1; tick(); ret_pop = 1'b0;
    chk("ret_pc", 32'(pc_current_value), 32'h12);

    // overflow after 17 calls, top entry intact, then drain to underflow
    for (int i = 0; i < 17; i++) begin
      call_push = 1'b1; pc_en = 1'b1; pc_load_val = 8'(8'h20 + i); tick();
    end
    idle_in();
    chk("ovf_after17", 32'(stack_overflow), 32'd1);
    ret_pop = 1'b1; tick();
    chk("entry15_intact", 32'(pc_current_value), 32'h2E);
    for (int i = 0; i < 15; i++) tick();
    chk("no_unf_yet", 32'(stack_underflow), 32'd0);
    tick(); ret_pop = 1'b0;
    chk("unf_flag", 32'(stack_underflow), 32'd1);
    chk("unf_pc_kept", 32'(pc_current_value), 32'h12);

    // mar_load while waiting must not issue a second request
    fixed_lat = 3;
    mar_load = 1'b1; tick(); mar_load = 1'b0;
    wait_phase(2, "glitch_wait");
    mar_load = 1'b1; tick(); tick(); mar_load = 1'b0;
    wait_phase(3, "glitch_data");
    ir_load = 1'b1; tick(); ir_load = 1'b0;
    chk("glitch_cmd", 32'(command_word), 32'(rom[8'h12]));
    tick();

    // reset while waiting; late rvalid is discarded
    fixed_lat = 2;
    mar_load = 1'b1; tick(); mar_load = 1'b0;
    wait_phase(2, "rst_wait");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready_reg_flag), 32'd0);
    chk("rst_ir", 32'(command_word), 32'd0);
    tick(); tick(); tick();
    chk("late_rvalid_busy", 32'(busy), 32'd0);
    chk("late_rvalid_ir", 32'(command_word), 32'd0);

    // random traffic
    stray_en  = 1'b1;
    fixed_lat = 0;
    repeat (2500) begin
      rst         = ($urandom_range(0, 299) == 0);
      mar_load    = ($urandom_range(0, 3) == 0);
      ir_load     = ($urandom_range(0, 2) == 0);
      pc_inc      = ($urandom_range(0, 3) == 0);
      pc_en       = ($urandom_range(0, 5) == 0);
      pc_load_val = 8'($urandom);
      call_push   = ($urandom_range(0, 5) == 0);
      ret_pop     = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    stray_en = 1'b0;
    repeat (10) tick();
    chk("addr_sb_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("cmd_sb_drained", 32'(exp_cmd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
